// File: rtl/fila_ctrl.sv
// Queue controller: arbitrates deserializer bytes and external dequeue requests
// into one-at-a-time enqueue/dequeue commands, confirming each via the queue length.
module fila_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic       clock_10KHz,
  input  logic       reset,
  input  logic       data_ready,
  input  logic [7:0] data_in,
  input  logic       dequeue_req,
  input  logic [3:0] len_in,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       full_out,
  output logic       empty_out,
  output logic       error_out
);

  localparam int            TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
  localparam logic [4:0]    DEPTH_W   = 5'(DEPTH);
  localparam logic          GRANT_ENQ = 1'b0;
  localparam logic          GRANT_DEQ = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENQ      = 3'd1,
    ENQ_WAIT = 3'd2,
    ACK      = 3'd3,
    DEQ      = 3'd4,
    DEQ_WAIT = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [TW-1:0] timer_inc;
  logic [3:0]    len_snap;
  logic [3:0]    len_snap_next;
  logic          last_grant;
  logic          last_grant_next;
  logic [7:0]    data_next;
  logic          error_next;
  logic          enq_ok;
  logic          deq_ok;
  logic          timed_out;

  // Full also covers out-of-range lengths above DEPTH.
  assign full_out  = ({1'b0, len_in} >= DEPTH_W);
  assign empty_out = (len_in == 4'd0);
  assign enq_ok    = data_ready & ~full_out;
  assign deq_ok    = dequeue_req & ~empty_out;
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + TW'(1);
  assign timed_out = (timer_inc == TIMER_MAX);

  // State, datapath and strobe registers; strobes are decoded from the next state.
  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      len_snap    <= 4'd0;
      last_grant  <= GRANT_DEQ;
      data_out    <= 8'h00;
      error_out   <= 1'b0;
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      ack_out     <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= timer_next;
      len_snap    <= len_snap_next;
      last_grant  <= last_grant_next;
      data_out    <= data_next;
      error_out   <= error_next;
      enqueue_out <= (next_state == ENQ);
      dequeue_out <= (next_state == DEQ);
      ack_out     <= (next_state == ACK);
    end
  end

  // Next-state logic: round-robin grant in IDLE, then wait for len_in to confirm.
  always_comb begin
    next_state      = state;
    timer_next      = timer;
    len_snap_next   = len_snap;
    last_grant_next = last_grant;
    data_next       = data_out;
    error_next      = error_out;
    case (state)
      IDLE: begin
        if (enq_ok && (!deq_ok || (last_grant == GRANT_DEQ))) begin
          next_state      = ENQ;
          data_next       = data_in;
          last_grant_next = GRANT_ENQ;
        end else if (deq_ok) begin
          next_state      = DEQ;
          last_grant_next = GRANT_DEQ;
        end else begin
          next_state = IDLE;
        end
      end
      ENQ: begin
        len_snap_next = len_in;
        timer_next    = '0;
        next_state    = ENQ_WAIT;
      end
      ENQ_WAIT: begin
        if (len_in == len_snap + 4'd1) begin
          next_state = ACK;
        end else begin
          timer_next = timer_inc;
          if (timed_out) begin
            error_next = 1'b1;
            next_state = ACK;
          end else begin
            next_state = ENQ_WAIT;
          end
        end
      end
      // Leaving only once data_ready falls guarantees a byte is never enqueued twice.
      ACK: begin
        if (!data_ready) begin
          next_state = IDLE;
        end else begin
          next_state = ACK;
        end
      end
      DEQ: begin
        len_snap_next = len_in;
        timer_next    = '0;
        next_state    = DEQ_WAIT;
      end
      DEQ_WAIT: begin
        if (len_in == len_snap - 4'd1) begin
          next_state = IDLE;
        end else begin
          timer_next = timer_inc;
          if (timed_out) begin
            error_next = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = DEQ_WAIT;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fila_ctrl.sv
// Directed self-checking bench for fila_ctrl with a small registered queue-length model.
module tb_fila_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dequeue_req = 1'b0;
  logic [3:0] len_in;
  logic       enqueue_out;
  logic       dequeue_out;
  logic [7:0] data_out;
  logic       ack_out;
  logic       full_out;
  logic       empty_out;
  logic       error_out;

  logic       load = 1'b1;
  logic [3:0] load_val = 4'd0;
  logic       enq_en = 1'b1;
  logic       deq_en = 1'b1;
  logic [3:0] model_len;

  int checks = 0;
  int failures = 0;

  fila_ctrl #(.DEPTH(8), .TIMEOUT(4)) dut (
    .clock_10KHz(clk),
    .reset(reset),
    .data_ready(data_ready),
    .data_in(data_in),
    .dequeue_req(dequeue_req),
    .len_in(len_in),
    .enqueue_out(enqueue_out),
    .dequeue_out(dequeue_out),
    .data_out(data_out),
    .ack_out(ack_out),
    .full_out(full_out),
    .empty_out(empty_out),
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Queue model: length updates on the edge that samples a strobe, like a registered len_out.
  always @(posedge clk) begin
    if (load) model_len <= load_val;
    else model_len <= model_len + ((enq_en && enqueue_out) ? 4'd1 : 4'd0)
                                - ((deq_en && dequeue_out) ? 4'd1 : 4'd0);
  end
  assign len_in = model_len;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; load_val = 4'd0;
    tick(); tick();
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL rst_enq got=%b exp=0", enqueue_out); end
    checks++; if (dequeue_out !== 1'b0) begin failures++; $display("FAIL rst_deq got=%b exp=0", dequeue_out); end
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack_out); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", error_out); end
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty_out); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full_out); end
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_enqueue();
    data_in = 8'hA5; data_ready = 1'b1;
    tick();
    checks++; if (enqueue_out !== 1'b1) begin failures++; $display("FAIL enq_strobe got=%b exp=1", enqueue_out); end
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL enq_data got=%h exp=a5", data_out); end
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL enq_ack_early got=%b exp=0", ack_out); end
    tick();
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL enq_one_cycle got=%b exp=0", enqueue_out); end
    checks++; if (len_in !== 4'd1) begin failures++; $display("FAIL enq_len got=%0d exp=1", len_in); end
    tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL enq_ack got=%b exp=1", ack_out); end
    tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL enq_ack_hold got=%b exp=1", ack_out); end
    data_ready = 1'b0;
    tick();
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL enq_ack_drop got=%b exp=0", ack_out); end
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL enq_no_repeat got=%b exp=0", enqueue_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL enq_err got=%b exp=0", error_out); end
  endtask

  task automatic test_backpressure();
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; data_in = 8'h3C; data_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL bp_enq got=%b exp=0", enqueue_out); end
      checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL bp_ack got=%b exp=0", ack_out); end
      checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL bp_full got=%b exp=1", full_out); end
      checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL bp_data_hold got=%h exp=a5", data_out); end
    end
    dequeue_req = 1'b1;
    tick();
    checks++; if (dequeue_out !== 1'b1) begin failures++; $display("FAIL bp_deq got=%b exp=1", dequeue_out); end
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL bp_deq_enq got=%b exp=0", enqueue_out); end
    dequeue_req = 1'b0;
    tick();
    checks++; if (dequeue_out !== 1'b0) begin failures++; $display("FAIL bp_deq_one got=%b exp=0", dequeue_out); end
    checks++; if (len_in !== 4'd7) begin failures++; $display("FAIL bp_len got=%0d exp=7", len_in); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL bp_notfull got=%b exp=0", full_out); end
    tick();
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL bp_wait_enq got=%b exp=0", enqueue_out); end
    tick();
    checks++; if (enqueue_out !== 1'b1) begin failures++; $display("FAIL bp_resume_enq got=%b exp=1", enqueue_out); end
    checks++; if (data_out !== 8'h3C) begin failures++; $display("FAIL bp_resume_data got=%h exp=3c", data_out); end
    tick(); tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL bp_ack2 got=%b exp=1", ack_out); end
    data_ready = 1'b0;
    tick();
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL bp_ack2_drop got=%b exp=0", ack_out); end
    checks++; if (len_in !== 4'd8) begin failures++; $display("FAIL bp_len_final got=%0d exp=8", len_in); end
  endtask

  task automatic test_round_robin();
    int grants;
    reset = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    reset = 1'b0; load = 1'b0; data_in = 8'h11; data_ready = 1'b1; dequeue_req = 1'b1;
    grants = 0;
    for (int c = 0; c < 80 && grants < 6; c++) begin
      tick();
      checks++; if (enqueue_out && dequeue_out) begin failures++; $display("FAIL rr_overlap got=11 exp=not both"); end
      if (enqueue_out || dequeue_out) begin
        checks++;
        if (enqueue_out !== ((grants % 2) == 0)) begin
          failures++; $display("FAIL rr_order grant=%0d got_enq=%b exp_enq=%b", grants, enqueue_out, ((grants % 2) == 0));
        end
        grants++;
      end
      if (ack_out) data_ready = 1'b0;
      else begin
        if (!data_ready) data_in = data_in + 8'd1;
        data_ready = 1'b1;
      end
    end
    checks++; if (grants != 6) begin failures++; $display("FAIL rr_timeout got=%0d exp=6 grants", grants); end
    dequeue_req = 1'b0; data_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", error_out); end
  endtask

  task automatic test_timeout();
    reset = 1'b1; load = 1'b1; load_val = 4'd2; enq_en = 1'b0;
    tick();
    reset = 1'b0; load = 1'b0; data_in = 8'h5A; data_ready = 1'b1;
    tick();
    checks++; if (enqueue_out !== 1'b1) begin failures++; $display("FAIL to_enq got=%b exp=1", enqueue_out); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL to_err_early cyc=%0d got=%b exp=0", i, error_out); end
      checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL to_ack_early cyc=%0d got=%b exp=0", i, ack_out); end
    end
    tick();
    checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", error_out); end
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL to_ack got=%b exp=1", ack_out); end
    data_ready = 1'b0;
    tick();
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL to_ack_drop got=%b exp=0", ack_out); end
    tick(); tick();
    checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", error_out); end
    checks++; if (enqueue_out !== 1'b0) begin failures++; $display("FAIL to_no_retry got=%b exp=0", enqueue_out); end
    enq_en = 1'b1;
  endtask

  task automatic test_reset_in_ack();
    data_in = 8'hC3; data_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL ra_ack got=%b exp=1", ack_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL ra_async_ack got=%b exp=0", ack_out); end
    checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL ra_async_err got=%b exp=0", error_out); end
    checks++; if (enqueue_out !== 1'b0 || dequeue_out !== 1'b0) begin failures++; $display("FAIL ra_async_strobes got=%b%b exp=00", enqueue_out, dequeue_out); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL ra_async_data got=%h exp=00", data_out); end
    data_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (ack_out !== 1'b0) begin failures++; $display("FAIL ra_idle_ack got=%b exp=0", ack_out); end
    data_in = 8'h77; data_ready = 1'b1;
    tick();
    checks++; if (enqueue_out !== 1'b1) begin failures++; $display("FAIL ra_reenq got=%b exp=1", enqueue_out); end
    checks++; if (data_out !== 8'h77) begin failures++; $display("FAIL ra_redata got=%h exp=77", data_out); end
    tick(); tick();
    checks++; if (ack_out !== 1'b1) begin failures++; $display("FAIL ra_reack got=%b exp=1", ack_out); end
    data_ready = 1'b0;
    tick();
  endtask

  task automatic test_flags();
    logic [3:0] vals [6];
    logic       exp_full [6];
    logic       exp_empty [6];
    vals      = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd15};
    exp_full  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_empty = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    data_ready = 1'b0; dequeue_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; load_val = vals[i];
      tick();
      checks++; if (full_out !== exp_full[i]) begin failures++; $display("FAIL flag_full len=%0d got=%b exp=%b", vals[i], full_out, exp_full[i]); end
      checks++; if (empty_out !== exp_empty[i]) begin failures++; $display("FAIL flag_empty len=%0d got=%b exp=%b", vals[i], empty_out, exp_empty[i]); end
    end
    load_val = 4'd0;
    tick();
    load = 1'b0; dequeue_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dequeue_out !== 1'b0) begin failures++; $display("FAIL empty_deq got=%b exp=0", dequeue_out); end
      checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL empty_flag got=%b exp=1", empty_out); end
    end
    dequeue_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_backpressure();
    test_round_robin();
    test_timeout();
    test_reset_in_ack();
    test_flags();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
